// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard stalls, branch flushes, memory-wait freeze with timeout.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        if_id_flush,
  output logic        id_ex_we,
  output logic        id_ex_bubble,
  output logic        ex_mem_we,
  output logic        mem_wb_bubble,
  output logic        mem_error,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t          state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic            mem_error_q;
  logic            drop_q;
  logic            frozen;

  // drop_q marks the RUN cycle right after a timeout, where the abandoned access counts as done.
  always_comb begin
    if (state_q == RUN) begin
      frozen = mem_req && !mem_ready && !drop_q;
    end else begin
      frozen = !mem_ready;
    end
  end

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_we      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_we     = 1'b1;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_we      = 1'b0;
      id_ex_bubble  = 1'b1;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (frozen) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (hazard) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_bubble  = 1'b1;
    end else if (branch_taken) begin
      if_id_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      case (state_q)
        RUN: begin
          if (frozen) begin
            state_q    <= MEM_WAIT;
            wait_cnt_q <= CW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
          end else if (wait_cnt_q == CW'(MEM_TIMEOUT)) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            mem_error_q <= 1'b1;
            drop_q      <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q    <= RUN;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_error = mem_error_q && !rst;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != 32'hFFFF_FFFF)) begin
        stall_q <= stall_q + 32'd1;
      end
      if (if_id_flush && (flush_q != 32'hFFFF_FFFF)) begin
        flush_q <= flush_q + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: one instance with MEM_TIMEOUT=4, one with the default 16.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b1;
  logic branch_taken = 1'b0;
  logic mem_req = 1'b1;
  logic mem_ready = 1'b0;

  logic        a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_we, a_id_ex_bubble, a_ex_mem_we, a_mem_wb_bubble, a_mem_error;
  logic [31:0] a_stall_cycles, a_flush_count;
  logic        b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_we, b_id_ex_bubble, b_ex_mem_we, b_mem_wb_bubble, b_mem_error;
  logic [31:0] b_stall_cycles, b_flush_count;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  // Control vector order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, ex_mem_we, mem_wb_bubble
  localparam logic [6:0] NRM = 7'b1101010;
  localparam logic [6:0] FRZ = 7'b0000001;
  localparam logic [6:0] HAZ = 7'b0001110;
  localparam logic [6:0] BRF = 7'b1111010;
  localparam logic [6:0] RST = 7'b0010101;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_TIMEOUT(4)) u_t4 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(a_pc_we), .if_id_we(a_if_id_we), .if_id_flush(a_if_id_flush),
    .id_ex_we(a_id_ex_we), .id_ex_bubble(a_id_ex_bubble), .ex_mem_we(a_ex_mem_we),
    .mem_wb_bubble(a_mem_wb_bubble), .mem_error(a_mem_error),
    .stall_cycles(a_stall_cycles), .flush_count(a_flush_count)
  );

  pipeline_stall_ctrl #(.MEM_TIMEOUT(16)) u_t16 (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_we(b_pc_we), .if_id_we(b_if_id_we), .if_id_flush(b_if_id_flush),
    .id_ex_we(b_id_ex_we), .id_ex_bubble(b_id_ex_bubble), .ex_mem_we(b_ex_mem_we),
    .mem_wb_bubble(b_mem_wb_bubble), .mem_error(b_mem_error),
    .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
  );

  wire [6:0] a_ctl = {a_pc_we, a_if_id_we, a_if_id_flush, a_id_ex_we, a_id_ex_bubble, a_ex_mem_we, a_mem_wb_bubble};
  wire [6:0] b_ctl = {b_pc_we, b_if_id_we, b_if_id_flush, b_id_ex_we, b_id_ex_bubble, b_ex_mem_we, b_mem_wb_bubble};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  // One pipeline cycle: apply inputs after the edge, check the T=4 instance mid-cycle.
  task automatic cyc(input string tag, input logic r, input logic h, input logic b,
                     input logic mr, input logic rdy, input logic [6:0] exp_ctl, input logic exp_err);
    @(posedge clk);
    #1;
    rst = r; hazard = h; branch_taken = b; mem_req = mr; mem_ready = rdy;
    #2;
    chk({tag, ".ctl"}, 32'(a_ctl), 32'(exp_ctl));
    chk({tag, ".err"}, 32'(a_mem_error), 32'(exp_err));
    if (!r) begin
`ifdef PIPE_PERF_CNT_EN
      chk({tag, ".stall"}, a_stall_cycles, 32'(exp_stall));
      chk({tag, ".flush"}, a_flush_count, 32'(exp_flush));
      if (!exp_ctl[6]) exp_stall++;
      if (exp_ctl[4])  exp_flush++;
`else
      chk({tag, ".stall"}, a_stall_cycles, 32'd0);
      chk({tag, ".flush"}, a_flush_count, 32'd0);
`endif
    end else begin
      exp_stall = 0;
      exp_flush = 0;
    end
  endtask

  initial begin
    // Reset held 3 cycles with hazard and a pending memory request
    for (int i = 0; i < 3; i++) begin
      cyc("rst", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, RST, 1'b0);
      chk("rst.t16.ctl", 32'(b_ctl), 32'(RST));
    end
    cyc("idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);

    // Load-use stall, then normal
    cyc("haz", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, HAZ, 1'b0);
    cyc("haz.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);

    // Hazard and branch together: hazard wins, branch acted on next cycle
    cyc("hazbr", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, HAZ, 1'b0);
    cyc("br", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BRF, 1'b0);
    cyc("br.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);

    // Memory access with 3 wait cycles on both instances
    for (int i = 0; i < 3; i++) begin
      cyc("mw.frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
      chk("mw.t16.frz", 32'(b_ctl), 32'(FRZ));
    end
    cyc("mw.rel", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, NRM, 1'b0);
    chk("mw.t16.rel", 32'(b_ctl), 32'(NRM));
    cyc("mw.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);
    chk("mw.t16.after", 32'(b_ctl), 32'(NRM));
    chk("mw.t16.err", 32'(b_mem_error), 32'd0);

    // Branch pending across a 2-cycle freeze flushes only in the release cycle
    for (int i = 0; i < 2; i++) begin
      cyc("pb.frz", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, 1'b0);
    end
    cyc("pb.rel", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, BRF, 1'b0);
    cyc("pb.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);

    // Timeout with MEM_TIMEOUT=4: 5 frozen cycles, then the access is dropped
    for (int i = 0; i < 5; i++) begin
      cyc("to.frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b0);
    end
    cyc("to.drop", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, NRM, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc("to.sticky", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b1);
    end

    // Reset in the middle of a wait aborts it without raising mem_error
    cyc("rw.frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b1);
    cyc("rw.frz", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, 1'b1);
    cyc("rw.rst", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, RST, 1'b0);
    cyc("rw.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);
    chk("rw.t16.ctl", 32'(b_ctl), 32'(NRM));
    chk("rw.t16.err", 32'(b_mem_error), 32'd0);

    // Back-to-back hazards cost one cycle each
    cyc("bb.haz1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, HAZ, 1'b0);
    cyc("bb.haz2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, HAZ, 1'b0);
    cyc("bb.after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);
    cyc("bb.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, NRM, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
